// File: rtl/wdt_pkg.sv
// wdt_pkg: shared state encoding and widths for the watchdog servicer
package wdt_pkg;
  localparam int WDT_CNT_W = 8;
  localparam int WDT_RETRY_W = 4;
  typedef enum logic [2:0] {IDLE, ARM, KICK, RECOVER, ESCALATE} wdt_state_t;
endpackage

// File: rtl/wdt_period_counter.sv
// wdt_period_counter: window/kick-width counter that wraps to zero at PERIOD-1
module wdt_period_counter
  import wdt_pkg::*;
#(
  parameter int PERIOD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 en,
  output logic [WDT_CNT_W-1:0] count,
  output logic                 terminal
);
  assign terminal = count == WDT_CNT_W'(PERIOD - 1);
  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else if (en) count <= terminal ? '0 : count + 1'b1;
  end
endmodule

// File: rtl/watchdog_servicer.sv
// watchdog_servicer: kicks an external watchdog while the supervised task is alive, recovers or escalates on expiry
module watchdog_servicer
  import wdt_pkg::*;
#(
  parameter int KICK_PERIOD = 8,
  parameter int KICK_WIDTH  = 2,
  parameter int MAX_RETRIES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   task_alive,
  input  logic                   interrupt,
  output logic                   data_out,
  output logic                   recovering,
  output logic                   sys_reset_req,
  output logic [WDT_RETRY_W-1:0] retry_count
);
  localparam logic [WDT_RETRY_W-1:0] MAX_R = WDT_RETRY_W'(MAX_RETRIES);
  localparam logic [WDT_CNT_W-1:0] KW_LAST = WDT_CNT_W'(KICK_WIDTH - 1);
  wdt_state_t state;
  logic alive_seen, terminal, kick_done, cnt_en;
  logic [WDT_CNT_W-1:0] count;
  logic [WDT_RETRY_W-1:0] retry_inc;
  // one counter times both the service window in ARM and the pulse width in KICK
  assign cnt_en = state == ARM || state == KICK;
  assign kick_done = state == KICK && count == KW_LAST;
  assign retry_inc = retry_count == MAX_R ? MAX_R : retry_count + 1'b1;
  wdt_period_counter #(.PERIOD(KICK_PERIOD)) u_cnt (
    .clk(clk), .rst(rst), .clear(!cnt_en || kick_done), .en(cnt_en),
    .count(count), .terminal(terminal)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data_out <= 1'b0;
      recovering <= 1'b0;
      sys_reset_req <= 1'b0;
      retry_count <= '0;
      alive_seen <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          data_out <= 1'b0;
          alive_seen <= 1'b0;
          if (enable) state <= ARM;
        end
        ARM, KICK: begin
          if (interrupt) begin
            state <= RECOVER;
            retry_count <= retry_inc;
            recovering <= 1'b1;
            data_out <= 1'b0;
            alive_seen <= 1'b0;
          end else if (!enable) begin
            state <= IDLE;
            data_out <= 1'b0;
            alive_seen <= 1'b0;
          end else if (state == ARM) begin
            if (terminal && (alive_seen || task_alive)) begin
              state <= KICK;
              data_out <= 1'b1;
              alive_seen <= 1'b0;
            end else alive_seen <= alive_seen || task_alive;
          end else if (kick_done) begin
            state <= ARM;
            data_out <= 1'b0;
            retry_count <= '0;
          end
        end
        RECOVER: begin
          if (retry_count == MAX_R) begin
            state <= ESCALATE;
            sys_reset_req <= 1'b1;
            recovering <= 1'b0;
          end else if (!interrupt && task_alive) begin
            state <= KICK;
            data_out <= 1'b1;
            recovering <= 1'b0;
          end
        end
        ESCALATE: begin
          sys_reset_req <= 1'b1;
          data_out <= 1'b0;
          recovering <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_watchdog_servicer.sv
// tb_watchdog_servicer: directed checks of kick timing, recovery, escalation and reset
module tb_watchdog_servicer;
  logic clk = 1'b0;
  logic rst, enable, task_alive, interrupt;
  logic data_out, recovering, sys_reset_req;
  logic [3:0] retry_count;
  int total = 0, bad = 0, highs;
  always #5 clk = ~clk;
  watchdog_servicer dut (
    .clk(clk), .rst(rst), .enable(enable), .task_alive(task_alive), .interrupt(interrupt),
    .data_out(data_out), .recovering(recovering), .sys_reset_req(sys_reset_req),
    .retry_count(retry_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1; enable = 1'b0; task_alive = 1'b0; interrupt = 1'b0;
    step;
    step;
    rst = 1'b0;
  endtask
  task automatic check_rst(input string tag);
    check({tag, "_dout"}, 32'(data_out), 0);
    check({tag, "_rec"}, 32'(recovering), 0);
    check({tag, "_sys"}, 32'(sys_reset_req), 0);
    check({tag, "_retry"}, 32'(retry_count), 0);
  endtask
  initial begin
    do_reset;
    check_rst("reset");
    // periodic service: alive mid-window first, then on the last window cycle
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      task_alive = (i == 3) || (i > 10 && i % 10 == 8);
      step;
      check($sformatf("periodic_dout_%0d", i), 32'(data_out), 32'(i % 10 == 8 || i % 10 == 9));
    end
    task_alive = 1'b0;
    check("periodic_retry", 32'(retry_count), 0);
    // no heartbeat: never kick
    do_reset;
    enable = 1'b1;
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      step;
      highs += int'(data_out);
    end
    check("no_alive_kicks", 32'(highs), 0);
    // disable drops to IDLE and forgets a seen heartbeat
    do_reset;
    enable = 1'b1;
    step;
    task_alive = 1'b1;
    step;
    task_alive = 1'b0;
    enable = 1'b0;
    step;
    check("disable_dout", 32'(data_out), 0);
    enable = 1'b1;
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      step;
      highs += int'(data_out);
    end
    check("disable_forgets_alive", 32'(highs), 0);
    // single interrupt then recovery kick
    do_reset;
    enable = 1'b1;
    step;
    step;
    interrupt = 1'b1;
    step;
    interrupt = 1'b0;
    check("int_rec", 32'(recovering), 1);
    check("int_retry", 32'(retry_count), 1);
    check("int_dout", 32'(data_out), 0);
    step;
    check("int_wait_rec", 32'(recovering), 1);
    task_alive = 1'b1;
    step;
    task_alive = 1'b0;
    check("rk_dout1", 32'(data_out), 1);
    check("rk_rec", 32'(recovering), 0);
    step;
    check("rk_dout2", 32'(data_out), 1);
    step;
    check("rk_end_dout", 32'(data_out), 0);
    check("rk_end_retry", 32'(retry_count), 0);
    // three interrupts without a completed kick escalate
    do_reset;
    enable = 1'b1;
    step;
    interrupt = 1'b1;
    step;
    interrupt = 1'b0; task_alive = 1'b1;
    step;
    task_alive = 1'b0; interrupt = 1'b1;
    step;
    check("esc_retry2", 32'(retry_count), 2);
    check("esc_dout2", 32'(data_out), 0);
    interrupt = 1'b0; task_alive = 1'b1;
    step;
    task_alive = 1'b0; interrupt = 1'b1;
    step;
    interrupt = 1'b0;
    check("esc_retry3", 32'(retry_count), 3);
    check("esc_rec3", 32'(recovering), 1);
    step;
    check("esc_sys", 32'(sys_reset_req), 1);
    check("esc_rec", 32'(recovering), 0);
    task_alive = 1'b1; enable = 1'b0;
    for (int i = 0; i < 5; i++) step;
    task_alive = 1'b0;
    check("esc_sticky", 32'(sys_reset_req), 1);
    check("esc_sticky_dout", 32'(data_out), 0);
    do_reset;
    check_rst("esc_cleared");
    // interrupt beats disable; enable ignored in RECOVER
    enable = 1'b1;
    step;
    step;
    enable = 1'b0; interrupt = 1'b1;
    step;
    interrupt = 1'b0;
    check("prio_rec", 32'(recovering), 1);
    task_alive = 1'b1;
    step;
    task_alive = 1'b0;
    check("prio_kick", 32'(data_out), 1);
    step;
    check("prio_idle_dout", 32'(data_out), 0);
    // reset on the second kick cycle overrides everything
    do_reset;
    enable = 1'b1;
    step;
    interrupt = 1'b1;
    step;
    interrupt = 1'b0; task_alive = 1'b1;
    step;
    task_alive = 1'b0;
    check("mid_kick_dout", 32'(data_out), 1);
    check("mid_kick_retry", 32'(retry_count), 1);
    rst = 1'b1; interrupt = 1'b1;
    step;
    check_rst("mid_kick_rst");
    rst = 1'b0; interrupt = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
